// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder front end.
package encoder_pkg;

    typedef logic [1:0] quad_t;

    typedef enum logic {
        PRIME,
        RUN
    } fsm_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_t;

    // Wide enough for any practical period width; the top slices it down.
    localparam logic [63:0] PERIOD_ALL_ONES = '1;

    // Position of {A,B} along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] quad_index(input quad_t ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Classify a transition: one position ahead is forward, one behind is
    // reverse, two apart means both channels moved at once.
    function automatic step_t quad_step(input quad_t prev, input quad_t curr);
        logic [1:0] delta;
        step_t      step;
        delta = quad_index(curr) - quad_index(prev);
        case (delta)
            2'd0:    step = STEP_NONE;
            2'd1:    step = STEP_FWD;
            2'd3:    step = STEP_REV;
            default: step = STEP_ERR;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// Two-flop synchronizer followed by a stability counter for one encoder channel.
module glitch_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_b,
    input  logic raw,
    input  logic track,
    output logic filtered
);
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Accept a new level only after it has held for FILTER_CYCLES samples;
    // while tracking, follow the synchronized level with no delay.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            filtered   <= 1'b0;
            stable_cnt <= '0;
        end else if (track) begin
            filtered   <= sync_2;
            stable_cnt <= '0;
        end else if (sync_2 == filtered) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CW'(FILTER_CYCLES - 1)) begin
            filtered   <= sync_2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/quadrature_input_conditioner.sv
// Quadrature front end: deglitch, decode to a position count, measure step
// period and flag stalls / illegal transitions.
//
// state | meaning
// PRIME | filters follow the pins directly, no steps decoded, timer held at 0
// RUN   | normal decode; stays here until reset
module quadrature_input_conditioner
    import encoder_pkg::*;
#(
    parameter int FILTER_CYCLES = 4,
    parameter int COUNT_WIDTH   = 32,
    parameter int PERIOD_WIDTH  = 32,
    parameter int STALL_CYCLES  = 2048
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    encoder_a,
    input  logic                    encoder_b,
    input  logic                    clear_count,
    output logic [COUNT_WIDTH-1:0]  encoder_count,
    output logic                    state_change,
    output logic                    direction,
    output logic [PERIOD_WIDTH-1:0] time_per_tick,
    output logic                    stalled,
    output logic                    quad_error
);
    localparam int PRIME_CYCLES = FILTER_CYCLES + 2;
    localparam int PCW          = $clog2(PRIME_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_NONE = PERIOD_ALL_ONES[PERIOD_WIDTH-1:0];
    localparam logic [PERIOD_WIDTH-1:0] STALL_LAST  = PERIOD_WIDTH'(STALL_CYCLES - 1);

    fsm_t                    state_q, state_d;
    logic [PCW-1:0]          prime_cnt;
    logic                    track;
    logic                    filt_a, filt_b;
    quad_t                   curr_ab, prev_ab;
    step_t                   step;
    logic                    step_valid;
    logic [PERIOD_WIDTH-1:0] elapsed;
    logic [PERIOD_WIDTH-1:0] period_meas;
    logic                    meas_valid;

    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_a (
        .clk      (clk),
        .rst_b    (reset),
        .raw      (encoder_a),
        .track    (track),
        .filtered (filt_a)
    );

    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter_b (
        .clk      (clk),
        .rst_b    (reset),
        .raw      (encoder_b),
        .track    (track),
        .filtered (filt_b)
    );

    assign curr_ab = {filt_a, filt_b};

    // State register plus the priming interval counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= PRIME;
            prime_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == PRIME) prime_cnt <= prime_cnt + PCW'(1);
        end
    end

    // Leave PRIME once the synchronizers and filters have settled.
    always_comb begin
        state_d = state_q;
        track   = 1'b0;
        if (state_q == PRIME) begin
            track = 1'b1;
            if (prime_cnt == PCW'(PRIME_CYCLES - 1)) state_d = RUN;
        end
    end

    // Step classification and the saturating period candidate.
    always_comb begin
        step        = STEP_NONE;
        period_meas = elapsed;
        if (state_q == RUN) step = quad_step(prev_ab, curr_ab);
        if (elapsed != PERIOD_NONE) period_meas = elapsed + PERIOD_WIDTH'(1);
    end

    assign step_valid = (step == STEP_FWD) || (step == STEP_REV);

    // Position count, direction and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_ab       <= 2'b00;
            encoder_count <= '0;
            state_change  <= 1'b0;
            direction     <= 1'b0;
            quad_error    <= 1'b0;
        end else begin
            prev_ab      <= curr_ab;
            state_change <= step_valid;
            if (clear_count)            encoder_count <= '0;
            else if (step == STEP_FWD)  encoder_count <= encoder_count + COUNT_WIDTH'(1);
            else if (step == STEP_REV)  encoder_count <= encoder_count - COUNT_WIDTH'(1);
            if (step_valid) direction <= (step == STEP_FWD);
            if (step == STEP_ERR)  quad_error <= 1'b1;
            else if (clear_count)  quad_error <= 1'b0;
        end
    end

    // Elapsed timer, period capture and stall detection; a period is only
    // trusted when the previous step was neither the first nor post-stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elapsed       <= '0;
            time_per_tick <= PERIOD_NONE;
            stalled       <= 1'b1;
            meas_valid    <= 1'b0;
        end else begin
            if (state_q == PRIME || step_valid) elapsed <= '0;
            else if (elapsed != PERIOD_NONE)    elapsed <= elapsed + PERIOD_WIDTH'(1);

            if (step_valid) begin
                stalled    <= 1'b0;
                meas_valid <= 1'b1;
                if (meas_valid) time_per_tick <= period_meas;
            end else if (state_q == RUN && elapsed == STALL_LAST) begin
                stalled       <= 1'b1;
                time_per_tick <= PERIOD_NONE;
                meas_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_input_conditioner.sv
// Directed bench for the quadrature input conditioner (default parameters).
module tb_quadrature_input_conditioner;

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        encoder_a;
    logic        encoder_b;
    logic        clear_count;
    logic [31:0] encoder_count;
    logic        state_change;
    logic        direction;
    logic [31:0] time_per_tick;
    logic        stalled;
    logic        quad_error;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    quadrature_input_conditioner dut (
        .clk           (clk),
        .reset         (reset),
        .encoder_a     (encoder_a),
        .encoder_b     (encoder_b),
        .clear_count   (clear_count),
        .encoder_count (encoder_count),
        .state_change  (state_change),
        .direction     (direction),
        .time_per_tick (time_per_tick),
        .stalled       (stalled),
        .quad_error    (quad_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset && state_change) pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive new pin levels; the step must appear exactly 7 edges later
    // (one to sample the pin, six of pipeline). gap = edges until return.
    task automatic do_step(input logic a, input logic b, input logic [31:0] exp_cnt,
                           input logic exp_dir, input logic [31:0] exp_tpt,
                           input int gap, input logic with_clear, input string tag);
        encoder_a = a;
        encoder_b = b;
        tick(6);
        chk({tag, " early"}, {31'b0, state_change}, 32'd0);
        if (with_clear) clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk({tag, " pulse"}, {31'b0, state_change}, 32'd1);
        chk({tag, " count"}, encoder_count, exp_cnt);
        chk({tag, " dir"},   {31'b0, direction}, {31'b0, exp_dir});
        chk({tag, " tpt"},   time_per_tick, exp_tpt);
        chk({tag, " stall"}, {31'b0, stalled}, 32'd0);
        tick(gap - 7);
    endtask

    initial begin
        reset       = 1'b0;
        encoder_a   = 1'b1;
        encoder_b   = 1'b1;
        clear_count = 1'b0;
        tick(3);
        chk("rst count", encoder_count, 32'd0);
        chk("rst pulse", {31'b0, state_change}, 32'd0);
        chk("rst dir",   {31'b0, direction}, 32'd0);
        chk("rst tpt",   time_per_tick, NONE);
        chk("rst stall", {31'b0, stalled}, 32'd1);
        chk("rst qerr",  {31'b0, quad_error}, 32'd0);

        // A=B=1 held through release: priming must not produce a step.
        reset = 1'b1;
        tick(12);
        chk("prime pulses", pulses, 32'd0);
        chk("prime count",  encoder_count, 32'd0);
        chk("prime stall",  {31'b0, stalled}, 32'd1);
        chk("prime tpt",    time_per_tick, NONE);

        // Four forward steps 20 cycles apart: 11->01->00->10->11.
        do_step(1'b0, 1'b1, 32'd1, 1'b1, NONE,  20, 1'b0, "fwd1");
        do_step(1'b0, 1'b0, 32'd2, 1'b1, 32'd20, 20, 1'b0, "fwd2");
        do_step(1'b1, 1'b0, 32'd3, 1'b1, 32'd20, 20, 1'b0, "fwd3");
        do_step(1'b1, 1'b1, 32'd4, 1'b1, 32'd20, 20, 1'b0, "fwd4");

        // 3-cycle low pulse on A is filtered out.
        encoder_a = 1'b0;
        tick(3);
        encoder_a = 1'b1;
        tick(12);
        chk("glitch3 count",  encoder_count, 32'd4);
        chk("glitch3 pulses", pulses, 32'd4);

        // 4-cycle low pulse: forward step, then reverse step 4 cycles later.
        encoder_a = 1'b0;
        tick(4);
        encoder_a = 1'b1;
        tick(3);
        chk("glitch4 fwd pulse", {31'b0, state_change}, 32'd1);
        chk("glitch4 fwd count", encoder_count, 32'd5);
        chk("glitch4 fwd dir",   {31'b0, direction}, 32'd1);
        tick(3);
        chk("glitch4 gap", {31'b0, state_change}, 32'd0);
        tick(1);
        chk("glitch4 rev pulse", {31'b0, state_change}, 32'd1);
        chk("glitch4 rev count", encoder_count, 32'd4);
        chk("glitch4 rev dir",   {31'b0, direction}, 32'd0);
        chk("glitch4 rev tpt",   time_per_tick, 32'd4);
        tick(10);

        // Both channels toggled together: illegal transition.
        encoder_a = 1'b0;
        encoder_b = 1'b0;
        tick(7);
        chk("err qerr",   {31'b0, quad_error}, 32'd1);
        chk("err count",  encoder_count, 32'd4);
        chk("err pulses", pulses, 32'd6);
        tick(5);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clr qerr",  {31'b0, quad_error}, 32'd0);
        chk("clr count", encoder_count, 32'd0);

        // Long idle: stall, then the first step keeps no measurement.
        tick(2060);
        chk("stall flag", {31'b0, stalled}, 32'd1);
        chk("stall tpt",  time_per_tick, NONE);
        do_step(1'b1, 1'b0, 32'd1, 1'b1, NONE,   30, 1'b0, "post_stall1");
        do_step(1'b1, 1'b1, 32'd2, 1'b1, 32'd30, 20, 1'b0, "post_stall2");

        // Reverse from zero wraps to all-ones; period spans the clear cycle.
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clr2 count", encoder_count, 32'd0);
        do_step(1'b1, 1'b0, NONE,  1'b0, 32'd21, 20, 1'b0, "rev_zero");
        do_step(1'b0, 1'b0, 32'd0, 1'b0, 32'd20, 20, 1'b1, "clr_with_step");
        chk("total pulses", pulses, 32'd10);
        chk("final qerr", {31'b0, quad_error}, 32'd0);

        do_step(1'b1, 1'b0, 32'd1, 1'b1, 32'd20, 10, 1'b0, "fwd_again");

        // Asynchronous reset mid-cycle takes effect without a clock edge.
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("async count", encoder_count, 32'd0);
        chk("async dir",   {31'b0, direction}, 32'd0);
        chk("async tpt",   time_per_tick, NONE);
        chk("async stall", {31'b0, stalled}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quadrature_input_conditioner.md
# quadrature_input_conditioner

Front end between the raw encoder pins and the velocity/commutation path of the BLDC velocity controller. Synchronizes and deglitches channels A/B, decodes quadrature steps into a signed position count, measures clock cycles between valid steps, and flags stalls and illegal transitions. It supplies the encoder count, step pulse and tick period consumed by the velocity lookup, velocity filter and torque-vector stages.

## Interface
- FILTER_CYCLES, 4: consecutive stable synchronized samples required to accept a channel level change (≥1)
- COUNT_WIDTH, 32: width of encoder_count
- PERIOD_WIDTH, 32: width of time_per_tick and the elapsed timer
- STALL_CYCLES, 2048: elapsed cycles with no valid step before stall is declared
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- encoder_a, encoder_b  in  1  raw asynchronous encoder channels
- clear_count  in  1  synchronous: zero encoder_count, clear quad_error
- encoder_count  out  COUNT_WIDTH  signed position, wraps modulo 2^COUNT_WIDTH
- state_change  out  1  one-cycle pulse per valid step
- direction  out  1  direction of last valid step (1 = forward, A leads B)
- time_per_tick  out  PERIOD_WIDTH  cycles between the last two valid steps; all-ones = no valid measurement
- stalled  out  1  no valid step within STALL_CYCLES
- quad_error  out  1  sticky: illegal two-bit transition seen

## Operation
- Reset values: encoder_count 0, state_change 0, direction 0, time_per_tick all-ones, stalled 1, quad_error 0; sync flops, filters, FSM cleared.
- Two-flop synchronizer per channel.
- Glitch filter per channel: counter increments while synchronized value ≠ filtered value, cleared when equal; on reaching FILTER_CYCLES, filtered value takes the synchronized value and counter clears.
- FSM PRIME → RUN. PRIME lasts FILTER_CYCLES+2 cycles after reset release; filtered values track synchronized values directly; no steps, timer held at 0. Then RUN permanently until reset.
- Decode in RUN on filtered {A,B} vs previous: forward sequence 00→10→11→01→00 (+1, direction 1); reverse (−1, direction 0). No change: nothing.
- Both bits change in one cycle: quad_error set, count and direction unchanged, no state_change, timer not restarted.
- clear_count with simultaneous step: count = 0 (step discarded from count), state_change still pulses, direction and period still update. clear_count with simultaneous error: quad_error ends 1.
- Elapsed timer: in RUN increments per cycle, saturates at all-ones; clears to 0 on valid step.
- On valid step: time_per_tick ← elapsed+1 (saturating) only if a measurement is valid, else stays all-ones. Measurement is invalid for the first step after PRIME and the first step after a stall.
- Stall: elapsed reaching STALL_CYCLES−1 → stalled 1, time_per_tick all-ones. Next valid step clears stalled.
- Direction reversal does not invalidate the period.

## Timing
- Raw edge sampled at edge k: state_change, encoder_count, direction, time_per_tick update at edge k+FILTER_CYCLES+2 (6 cycles at default).
- Glitches shorter than FILTER_CYCLES synchronized cycles never propagate.
- Steps N cycles apart, same or opposite direction → time_per_tick = N.
- Async reset mid-operation: all outputs take reset values immediately; PRIME restarts on release.

## Structure
- Package encoder_pkg: quad-state typedef (2-bit), FSM enum {PRIME, RUN}, forward/reverse step lookup function, all-ones period constant.
- Sub-module glitch_filter (synchronizer + stability counter), instantiated per channel; decode, timer and FSM in the top.

## Test plan
- A=B=1 held through reset release → after PRIME no state_change, count 0, stalled 1, time_per_tick FFFF_FFFF.
- Four forward steps 20 cycles apart → count 4, four pulses each 6 cycles after raw edge, direction 1, time_per_tick 20 from second step, stalled 0 after first.
- 3-cycle pulse on A → no change; 4-cycle pulse → one step then one reverse step on release.
- A and B toggled same cycle → quad_error 1, count unchanged; clear_count → quad_error 0, count 0.
- No edges for 2048 cycles → stalled 1, time_per_tick FFFF_FFFF; next step keeps FFFF_FFFF; following step 30 cycles later → 30.
- From count 0, one reverse step → FFFF_FFFF, direction 0; clear_count coincident with next step → count 0, state_change pulses.
